magnetron_ctrl: RTL and testbench
=================================

Name: magnetron_ctrl

Overview:
Cook-cycle controller for the microwave. It gates the magnetron through the Enabler output based on the front-panel keys (start, stop, clear), the door interlock and the cook timer's done flag. It sits between the keypad/timer logic and the magnetron drive stage. It is a single-clock registered FSM, so the magnetron can never be enabled combinationally.

Parameters:
SYNC_STAGES, 2, number of flip-flop stages in each input synchronizer; used only when MAGNETRON_SYNC_EN is defined; legal values 2..4.

Ports:
clk  input  1  system clock; all state changes on the rising edge
rst  input  1  synchronous, active-high reset
start  input  1  start key, active-low (0 = pressed)
stop  input  1  stop/pause key, active-low (0 = pressed)
clear  input  1  clear/cancel key, active-low (0 = pressed)
door_closed  input  1  door interlock, 1 = door closed
timer_done  input  1  cook timer expired, active-high
Enabler  output  1  magnetron enable, 1 = magnetron on; registered
state  output  2  current FSM state: IDLE=00, COOK=01, PAUSE=10, DONE=11
done  output  1  1 while in DONE; registered
door_fault  output  1  one-cycle pulse: start pressed while door open in IDLE or PAUSE

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high.
- Reset: state=IDLE, Enabler=0, done=0, door_fault=0.
- Registered outputs: Enabler=(state==COOK) and done=(state==DONE) are decoded from the registered state, with no combinational path from inputs.
- Latency: an input change sampled at edge N is reflected on the outputs after edge N.
- Key level: keys are level-sensitive. Holding start low has no extra effect once in COOK.
- Transition priority, each cycle, highest first: rst > clear low > door open (door_closed=0) > stop low > timer_done > start low.
- IDLE:
  - start=0, stop=1, door_closed=1, timer_done=0 -> COOK.
  - start=0 with door_closed=0 -> stay IDLE and pulse door_fault.
  - Otherwise stay IDLE.
- COOK:
  - clear=0 -> IDLE.
  - door_closed=0 -> PAUSE.
  - stop=0 -> PAUSE.
  - timer_done=1 -> DONE.
  - Otherwise stay COOK.
- PAUSE:
  - clear=0 -> IDLE.
  - Resume to COOK under the same conditions as IDLE->COOK.
  - start=0 with door open -> door_fault pulse, stay PAUSE.
  - timer_done is ignored.
- DONE:
  - clear=0 or door_closed=0 -> IDLE.
  - start is ignored; a new cycle needs clear or a door open first.
- Simultaneous events:
  - start and stop both low -> stop wins, no transition to COOK.
  - timer_done and start in IDLE -> stay IDLE.
  - Door opening at the same edge as timer_done in COOK -> PAUSE.
- Reset mid-cook: Enabler drops to 0 on the reset edge.
- Illegal state encodings are unreachable. The default branch forces IDLE with Enabler=0.
- door_fault is high for exactly one cycle per qualifying sampled cycle. Holding start low re-pulses every cycle.

Optional Feature:
MAGNETRON_SYNC_EN:
- Defined:
  - start, stop, clear, door_closed and timer_done each pass through a SYNC_STAGES-deep flip-flop synchronizer before the FSM.
  - Synchronizers reset to the inactive levels: start/stop/clear=1, door_closed=0, timer_done=0.
  - Input-to-output latency grows by SYNC_STAGES cycles.
- Undefined: inputs feed the FSM directly; latency is 1 cycle.

Test Plan:
1. Reset with start=1, stop=1, clear=1, door_closed=0, timer_done=0 -> Enabler=0, state=00, done=0.
2. Door closed, start=0 for one cycle -> Enabler=1 next cycle (state=01). Release start=1 -> Enabler stays 1.
3. In COOK, stop=0 -> Enabler=0, state=10. Open door, then close it and start=0 -> Enabler=1, state=01.
4. In COOK, door_closed=0 -> Enabler=0 the next cycle. start=0 with door open -> door_fault=1 for one cycle, Enabler stays 0.
5. In COOK, timer_done=1 -> state=11, done=1, Enabler=0. start=0 -> no change. clear=0 -> state=00, done=0.
6. In COOK, rst=1 for one edge -> Enabler=0, state=00. With MAGNETRON_SYNC_EN defined, the start response in scenario 2 appears SYNC_STAGES cycles later.

Source files
------------

// File: rtl/magnetron_ctrl.sv
// magnetron_ctrl: cook-cycle controller gating the magnetron drive.
// The Enabler output comes straight from a flop, so no key or interlock input
// can turn the magnetron on without first passing through the registered FSM.
// Optional build macro: MAGNETRON_SYNC_EN. When it is defined, every input
// passes through a SYNC_STAGES-deep synchronizer before it reaches the FSM.
module magnetron_ctrl #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic       clear,
  input  logic       door_closed,
  input  logic       timer_done,
  output logic       Enabler,
  output logic [1:0] state,
  output logic       done,
  output logic       door_fault
);

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_COOK  = 2'b01;
  localparam logic [1:0] ST_PAUSE = 2'b10;
  localparam logic [1:0] ST_DONE  = 2'b11;

  // An out-of-range synchronizer depth is a bad build; hold the FSM in IDLE so
  // the magnetron can never be enabled in that case.
  localparam logic CFG_OK = (SYNC_STAGES >= 2) && (SYNC_STAGES <= 4);

  // Inputs as seen by the FSM, packed {start, stop, clear, door_closed, timer_done}
  logic [4:0] raw_vec;
  logic [4:0] in_vec;
  logic       s_start;
  logic       s_stop;
  logic       s_clear;
  logic       s_door;
  logic       s_timer;

  assign raw_vec = {start, stop, clear, door_closed, timer_done};

`ifdef MAGNETRON_SYNC_EN
  // Clamp so the shift registers stay well-formed even for a bad parameter;
  // CFG_OK keeps the FSM idle in that case anyway.
  localparam int DEPTH = (SYNC_STAGES < 2) ? 2 : ((SYNC_STAGES > 4) ? 4 : SYNC_STAGES);
  // Reset to the inactive levels: keys released, door open, timer not done.
  localparam logic [4:0] SYNC_RST = 5'b11100;

  genvar gi;
  for (gi = 0; gi < 5; gi++) begin : g_sync
    logic [DEPTH-1:0] sh_reg;

    // Shift one input through its synchronizer chain
    always_ff @(posedge clk) begin
      if (rst) begin
        sh_reg <= {DEPTH{SYNC_RST[gi]}};
      end else begin
        sh_reg <= {sh_reg[DEPTH-2:0], raw_vec[gi]};
      end
    end

    assign in_vec[gi] = sh_reg[DEPTH-1];
  end
`else
  assign in_vec = raw_vec;
`endif

  assign {s_start, s_stop, s_clear, s_door, s_timer} = in_vec;

  logic [1:0] state_reg;
  logic [1:0] state_next;
  logic       enabler_reg;
  logic       done_reg;
  logic       door_fault_reg;
  logic       fault_next;
  logic       start_ok;

  // A start request that may begin or resume cooking: start pressed, stop
  // released, door closed and the timer not already expired.
  assign start_ok = !s_start && s_stop && s_door && !s_timer;

  // Next-state decode; each branch follows the priority
  // clear > door open > stop > timer_done > start.
  always_comb begin
    state_next = state_reg;
    fault_next = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (!s_clear) begin
          state_next = ST_IDLE;
        end else if (!s_door) begin
          fault_next = !s_start;
        end else if (start_ok) begin
          state_next = ST_COOK;
        end
      end
      ST_COOK: begin
        if (!s_clear) begin
          state_next = ST_IDLE;
        end else if (!s_door || !s_stop) begin
          state_next = ST_PAUSE;
        end else if (s_timer) begin
          state_next = ST_DONE;
        end
      end
      ST_PAUSE: begin
        if (!s_clear) begin
          state_next = ST_IDLE;
        end else if (!s_door) begin
          fault_next = !s_start;
        end else if (start_ok) begin
          state_next = ST_COOK;
        end
      end
      ST_DONE: begin
        // start is ignored here: the user must clear or open the door first
        if (!s_clear || !s_door) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
    if (!CFG_OK) begin
      state_next = ST_IDLE;
      fault_next = 1'b0;
    end
  end

  // State and output registers; Enabler and done are decoded from the next
  // state so that they always equal the decode of the registered state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      enabler_reg    <= 1'b0;
      done_reg       <= 1'b0;
      door_fault_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      enabler_reg    <= (state_next == ST_COOK);
      done_reg       <= (state_next == ST_DONE);
      door_fault_reg <= fault_next;
    end
  end

  assign state      = state_reg;
  assign Enabler    = enabler_reg;
  assign done       = done_reg;
  assign door_fault = door_fault_reg;

endmodule

// File: tb/tb_magnetron_ctrl.sv
// tb_magnetron_ctrl: directed scenarios followed by biased random key and
// interlock activity, all compared each cycle against a mode-level model of
// the cook cycle. Works with or without MAGNETRON_SYNC_EN.
module tb_magnetron_ctrl;

  localparam int SYNC_N = 2;
`ifdef MAGNETRON_SYNC_EN
  localparam int EXTRA = SYNC_N;
`else
  localparam int EXTRA = 0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       stop;
  logic       clear;
  logic       door_closed;
  logic       timer_done;
  logic       Enabler;
  logic [1:0] state;
  logic       done;
  logic       door_fault;

  int errors = 0;
  int checks = 0;

  magnetron_ctrl #(.SYNC_STAGES(SYNC_N)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .stop       (stop),
    .clear      (clear),
    .door_closed(door_closed),
    .timer_done (timer_done),
    .Enabler    (Enabler),
    .state      (state),
    .done       (done),
    .door_fault (door_fault)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef enum int {M_IDLE, M_COOK, M_PAUSE, M_DONE} mode_t;
  typedef struct packed {
    logic st;
    logic sp;
    logic cl;
    logic dc;
    logic td;
  } keys_t;

  localparam keys_t INACTIVE = '{st: 1'b1, sp: 1'b1, cl: 1'b1, dc: 1'b0, td: 1'b0};

  mode_t m_mode;
  bit    m_fault;
  keys_t pipe[$];

  function automatic logic [1:0] mode_code(mode_t m);
    case (m)
      M_COOK:  return 2'd1;
      M_PAUSE: return 2'd2;
      M_DONE:  return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  task automatic model_reset();
    m_mode  = M_IDLE;
    m_fault = 0;
    pipe.delete();
    for (int i = 0; i < EXTRA; i++) pipe.push_back(INACTIVE);
  endtask

  // One clock of the cook cycle, in terms of pressed keys and door/timer.
  task automatic model_clock(input keys_t raw);
    keys_t k;
    bit start_p, stop_p, clear_p, door_shut, expired, can_cook;
    pipe.push_back(raw);
    k = pipe.pop_front();
    start_p   = (k.st == 1'b0);
    stop_p    = (k.sp == 1'b0);
    clear_p   = (k.cl == 1'b0);
    door_shut = (k.dc == 1'b1);
    expired   = (k.td == 1'b1);
    can_cook  = start_p && !stop_p && door_shut && !expired;
    m_fault = 0;
    if (clear_p) begin
      m_mode = M_IDLE;
    end else begin
      case (m_mode)
        M_IDLE, M_PAUSE: begin
          if (!door_shut) m_fault = start_p;
          else if (can_cook) m_mode = M_COOK;
        end
        M_COOK: begin
          if (!door_shut || stop_p) m_mode = M_PAUSE;
          else if (expired) m_mode = M_DONE;
        end
        M_DONE: begin
          if (!door_shut) m_mode = M_IDLE;
        end
        default: m_mode = M_IDLE;
      endcase
    end
  endtask

  // ---------------- stimulus / check helpers ----------------
  task automatic check_outputs(input string tag);
    checks += 4;
    assert (state === mode_code(m_mode)) else begin
      errors++;
      $error("FAIL %s state: observed=%0d expected=%0d", tag, state, mode_code(m_mode));
    end
    assert (Enabler === (m_mode == M_COOK)) else begin
      errors++;
      $error("FAIL %s Enabler: observed=%0b expected=%0b", tag, Enabler, (m_mode == M_COOK));
    end
    assert (done === (m_mode == M_DONE)) else begin
      errors++;
      $error("FAIL %s done: observed=%0b expected=%0b", tag, done, (m_mode == M_DONE));
    end
    assert (door_fault === m_fault) else begin
      errors++;
      $error("FAIL %s door_fault: observed=%0b expected=%0b", tag, door_fault, m_fault);
    end
  endtask

  // Drive one cycle of inputs, clock it, update the model, then check.
  task automatic step(input string tag, input logic r, input logic st, input logic sp,
                      input logic cl, input logic dc, input logic td);
    keys_t k;
    rst = r; start = st; stop = sp; clear = cl; door_closed = dc; timer_done = td;
    k = '{st: st, sp: sp, cl: cl, dc: dc, td: td};
    @(posedge clk);
    if (r) model_reset();
    else model_clock(k);
    #1;
    $display("%s rst=%0b start=%0b stop=%0b clear=%0b door=%0b timer=%0b -> state=%0d en=%0b done=%0b fault=%0b",
             tag, r, st, sp, cl, dc, td, state, Enabler, done, door_fault);
    check_outputs(tag);
  endtask

  task automatic hold(input string tag, input int n, input logic st, input logic sp,
                      input logic cl, input logic dc, input logic td);
    for (int i = 0; i < n; i++) step(tag, 1'b0, st, sp, cl, dc, td);
  endtask

  initial begin
    model_reset();
    // 1. reset with keys released and door open
    step("reset", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    step("reset", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    // 2. close door, press start for one cycle, release
    hold("close", 1 + EXTRA, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    step("start", 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    hold("cook", 2 + EXTRA, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    hold("cook_hold_start", 2, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    // 3. stop pauses; open, close, restart
    step("stop", 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    hold("paused", 1 + EXTRA, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    hold("door_open", 1 + EXTRA, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    step("door_shut", 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    step("resume", 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    hold("cook", 1 + EXTRA, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    // 4. door opens while cooking; start with door open faults every cycle
    hold("cook_door_open", 1 + EXTRA, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    hold("fault", 3, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    hold("fault_release", 1 + EXTRA, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    step("resume_close", 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    step("resume_start", 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    hold("cook", 1 + EXTRA, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    // 5. timer expiry, start ignored in DONE, clear back to IDLE
    step("timer", 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    hold("done", 1 + EXTRA, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    hold("done_start", 2, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    hold("done_idle", EXTRA, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    step("clear", 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    hold("idle", 1 + EXTRA, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    // simultaneous events
    hold("start_and_stop", 2, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    hold("start_and_timer", 2, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    hold("idle", EXTRA, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    step("start", 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    hold("cook", 1 + EXTRA, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    step("door_and_timer", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    hold("paused", 1 + EXTRA, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    step("resume", 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    hold("cook", 1 + EXTRA, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    step("clear_cook", 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    hold("idle", 1 + EXTRA, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    // 6. reset in the middle of cooking
    step("start", 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    hold("cook", 1 + EXTRA, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    step("rst_mid_cook", 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    hold("after_rst", 2 + EXTRA, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);

    // biased random activity
    for (int i = 0; i < 600; i++) begin
      logic r, st, sp, cl, dc, td;
      r  = ($urandom_range(0, 199) == 0);
      st = ($urandom_range(0, 99) >= 30);
      sp = ($urandom_range(0, 99) >= 10);
      cl = ($urandom_range(0, 99) >= 5);
      dc = ($urandom_range(0, 99) < 85);
      td = ($urandom_range(0, 99) < 10);
      step("rand", r, st, sp, cl, dc, td);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
